// File: rtl/cpu8_pkg.sv
// Shared 8-bit CPU definitions: bus widths, fetch FSM state encoding and the HALT opcode.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu8_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    // Also the fill value of unprogrammed ROM, so running off the end of a program halts.
    localparam data_t HALT_OPCODE = 8'hFF;

    typedef enum logic [1:0] {
        ST_FETCH     = 2'd0,
        ST_VALID     = 2'd1,
        ST_STEP_WAIT = 2'd2,
        ST_HALTED    = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer_edge_rise.sv
// Rising-edge detector for a synchronous, already-debounced level (board buttons).
// Latency: rise is combinational from lvl, against the level registered on the previous edge.
// Backpressure: none; an edge not consumed in its cycle is lost.
module edge_rise (
    input  logic clk,
    input  logic rst,
    input  logic lvl,
    output logic rise
);

    logic lvl_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_q <= 1'b0;
        end else begin
            lvl_q <= lvl;
        end
    end

    assign rise = lvl & ~lvl_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch: owns the PC, registers ROM bytes and presents them to the decoder.
// Latency: one instruction per 2 cycles with instr_ready held high; jump target valid 2 cycles after handshake.
// Backpressure: instr/instr_pc hold in VALID until instr_ready; the PC does not advance meanwhile.
module fetch_sequencer #(
    parameter cpu8_pkg::addr_t RESET_PC    = 8'h00,
    parameter cpu8_pkg::data_t HALT_OPCODE = cpu8_pkg::HALT_OPCODE
) (
    input  logic                  clk,
    input  logic                  rst,
    output cpu8_pkg::addr_t       rom_addr,
    input  cpu8_pkg::data_t       rom_data,
    output cpu8_pkg::data_t       instr,
    output cpu8_pkg::addr_t       instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  jump_en,
    input  cpu8_pkg::addr_t       jump_addr,
    input  logic                  step_mode,
    input  logic                  step,
    input  logic                  resume,
    output logic                  halted
);

    import cpu8_pkg::*;

    fetch_state_t state;
    addr_t        pc;
    logic         step_rise;

    edge_rise u_step_edge (
        .clk  (clk),
        .rst  (rst),
        .lvl  (step),
        .rise (step_rise)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_FETCH;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    // A halt leaves pc on the HALT byte so resume can step past it.
                    if (rom_data == HALT_OPCODE) begin
                        halted <= 1'b1;
                        state  <= ST_HALTED;
                    end else begin
                        instr       <= rom_data;
                        instr_pc    <= pc;
                        pc          <= pc + 8'd1;
                        instr_valid <= 1'b1;
                        state       <= ST_VALID;
                    end
                end
                ST_VALID: begin
                    if (instr_ready) begin
                        if (jump_en) begin
                            pc <= jump_addr;
                        end
                        instr_valid <= 1'b0;
                        state       <= step_mode ? ST_STEP_WAIT : ST_FETCH;
                    end
                end
                ST_STEP_WAIT: begin
                    if (!step_mode || step_rise) begin
                        state <= ST_FETCH;
                    end
                end
                ST_HALTED: begin
                    if (jump_en) begin
                        pc     <= jump_addr;
                        halted <= 1'b0;
                        state  <= ST_FETCH;
                    end else if (resume) begin
                        pc     <= pc + 8'd1;
                        halted <= 1'b0;
                        state  <= ST_FETCH;
                    end
                end
                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end

    assign rom_addr = pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus a randomized run against a transaction-level PC model.
module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rom [256];

    logic [7:0] rom_addr, rom_data, instr, instr_pc;
    logic       instr_valid, halted;
    logic [7:0] rom_addr2, rom_data2, instr2, instr_pc2;
    logic       instr_valid2, halted2;

    logic       instr_ready = 1'b0;
    logic       jump_en = 1'b0;
    logic [7:0] jump_addr = 8'h00;
    logic       step_mode = 1'b0;
    logic       step = 1'b0;
    logic       resume = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign rom_data  = rom[rom_addr];
    assign rom_data2 = rom[rom_addr2];

    fetch_sequencer dut (
        .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_data(rom_data),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .jump_en(jump_en), .jump_addr(jump_addr), .step_mode(step_mode), .step(step),
        .resume(resume), .halted(halted)
    );

    fetch_sequencer #(.RESET_PC(8'hFE)) dut_wrap (
        .clk(clk), .rst(rst), .rom_addr(rom_addr2), .rom_data(rom_data2),
        .instr(instr2), .instr_pc(instr_pc2), .instr_valid(instr_valid2), .instr_ready(instr_ready),
        .jump_en(jump_en), .jump_addr(jump_addr), .step_mode(step_mode), .step(step),
        .resume(resume), .halted(halted2)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fill_rom(input logic [7:0] v);
        for (int i = 0; i < 256; i++) rom[i] = v;
    endtask

    task automatic fill_rom_counting();
        for (int i = 0; i < 256; i++) rom[i] = 8'(i & 127);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        jump_en = 1'b0; jump_addr = 8'h00; step = 1'b0; resume = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_count(input int n, output int cnt, output logic [7:0] last_pc);
        cnt = 0;
        last_pc = 8'hXX;
        for (int i = 0; i < n; i++) begin
            tick();
            if (instr_valid === 1'b1) begin
                cnt++;
                last_pc = instr_pc;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if (rom_addr !== 8'h00) begin n_fail++; $display("FAIL reset_rom_addr got %h want 00", rom_addr); end
        n_checks++; if (instr !== 8'h00) begin n_fail++; $display("FAIL reset_instr got %h want 00", instr); end
        n_checks++; if (instr_pc !== 8'h00) begin n_fail++; $display("FAIL reset_instr_pc got %h want 00", instr_pc); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", instr_valid); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b want 0", halted); end
        n_checks++; if (rom_addr2 !== 8'hFE) begin n_fail++; $display("FAIL reset_pc_param got %h want fe", rom_addr2); end
    endtask

    task automatic test_basic();
        logic [4:0] ev = 5'b00101;
        logic [4:0] eh = 5'b10000;
        fill_rom(8'hFF);
        rom[0] = 8'h11; rom[1] = 8'h22; rom[2] = 8'hFF;
        instr_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++; if (instr_valid !== ev[i]) begin n_fail++; $display("FAIL basic_valid[%0d] got %b want %b", i, instr_valid, ev[i]); end
            n_checks++; if (halted !== eh[i]) begin n_fail++; $display("FAIL basic_halted[%0d] got %b want %b", i, halted, eh[i]); end
            if (i == 0) begin
                n_checks++; if ({instr, instr_pc} !== 16'h1100) begin n_fail++; $display("FAIL basic_first got %h/%h want 11/00", instr, instr_pc); end
            end
            if (i == 2) begin
                n_checks++; if ({instr, instr_pc} !== 16'h2201) begin n_fail++; $display("FAIL basic_second got %h/%h want 22/01", instr, instr_pc); end
            end
            if (i == 4) begin
                n_checks++; if (rom_addr !== 8'h02) begin n_fail++; $display("FAIL basic_halt_addr got %h want 02", rom_addr); end
            end
        end
    endtask

    task automatic test_stall_jump();
        bit found = 1'b0;
        fill_rom_counting();
        rom[8'h80] = 8'h5A;
        instr_ready = 1'b0;
        do_reset();
        tick();
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin jump_en = 1'b1; jump_addr = 8'h40; end
            tick();
            jump_en = 1'b0;
            n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d] got %b want 1", k, instr_valid); end
            n_checks++; if ({instr, instr_pc} !== 16'h0000) begin n_fail++; $display("FAIL stall_instr[%0d] got %h/%h want 00/00", k, instr, instr_pc); end
            n_checks++; if (rom_addr !== 8'h01) begin n_fail++; $display("FAIL stall_rom_addr[%0d] got %h want 01", k, rom_addr); end
        end
        instr_ready = 1'b1;
        tick();
        n_checks++; if (rom_addr !== 8'h01) begin n_fail++; $display("FAIL stall_jump_ignored got %h want 01", rom_addr); end
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            if (instr_valid === 1'b1 && instr_pc === 8'h04) begin
                found = 1'b1;
                jump_en = 1'b1; jump_addr = 8'h80;
                tick();
                jump_en = 1'b0;
                n_checks++; if ({instr_valid, rom_addr} !== {1'b0, 8'h80}) begin n_fail++; $display("FAIL jump_fetch got %b/%h want 0/80", instr_valid, rom_addr); end
                tick();
                n_checks++; if ({instr_valid, instr_pc, instr} !== {1'b1, 8'h80, 8'h5A}) begin n_fail++; $display("FAIL jump_target got %b/%h/%h want 1/80/5a", instr_valid, instr_pc, instr); end
            end
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL jump_reach_pc4 got none want instr_pc 04"); end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_pc [3];
        logic [7:0] exp_d [3];
        int got = 0;
        exp_pc = '{8'hFE, 8'hFF, 8'h00};
        exp_d  = '{8'hA1, 8'hA2, 8'hA3};
        fill_rom(8'hFF);
        rom[8'hFE] = 8'hA1; rom[8'hFF] = 8'hA2; rom[0] = 8'hA3;
        instr_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            tick();
            if (instr_valid2 === 1'b1 && got < 3) begin
                n_checks++; if ({instr_pc2, instr2} !== {exp_pc[got], exp_d[got]}) begin n_fail++; $display("FAIL wrap[%0d] got %h/%h want %h/%h", got, instr_pc2, instr2, exp_pc[got], exp_d[got]); end
                got++;
            end
        end
        n_checks++; if (got != 3) begin n_fail++; $display("FAIL wrap_count got %0d want 3", got); end
    endtask

    task automatic test_step();
        int a, b;
        logic [7:0] pa, pb;
        fill_rom_counting();
        instr_ready = 1'b1;
        step_mode = 1'b1;
        do_reset();
        run_count(6, a, pa);
        n_checks++; if (a != 1 || pa !== 8'h00) begin n_fail++; $display("FAIL step_initial got %0d/%h want 1/00", a, pa); end
        for (int p = 0; p < 3; p++) begin
            step = 1'b1;
            run_count(1, a, pa);
            step = 1'b0;
            run_count(4, b, pb);
            if (a != 0) pb = pa;
            n_checks++; if (a + b != 1 || pb !== 8'(p + 1)) begin n_fail++; $display("FAIL step_pulse[%0d] got %0d/%h want 1/%h", p, a + b, pb, 8'(p + 1)); end
        end
        step = 1'b1;
        run_count(10, a, pa);
        step = 1'b0;
        run_count(3, b, pb);
        n_checks++; if (a + b != 1 || pa !== 8'h04) begin n_fail++; $display("FAIL step_held got %0d/%h want 1/04", a + b, pa); end
        step_mode = 1'b0;
        run_count(10, a, pa);
        n_checks++; if (a != 5 || pa !== 8'h09) begin n_fail++; $display("FAIL step_release got %0d/%h want 5/09", a, pa); end
    endtask

    task automatic test_halt_resume();
        bit seen = 1'b0;
        fill_rom(8'hFF);
        rom[0] = 8'h11; rom[1] = 8'h22; rom[3] = 8'h33; rom[4] = 8'h44; rom[8'h10] = 8'h77;
        instr_ready = 1'b1;
        step_mode = 1'b0;
        do_reset();
        for (int k = 0; k < 20 && !seen; k++) begin tick(); seen = halted; end
        tick();
        n_checks++; if ({halted, rom_addr} !== {1'b1, 8'h02}) begin n_fail++; $display("FAIL halt1 got %b/%h want 1/02", halted, rom_addr); end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        n_checks++; if ({halted, instr_valid, rom_addr} !== {2'b00, 8'h03}) begin n_fail++; $display("FAIL resume_fetch got %b/%b/%h want 0/0/03", halted, instr_valid, rom_addr); end
        tick();
        n_checks++; if ({instr_valid, instr_pc, instr} !== {1'b1, 8'h03, 8'h33}) begin n_fail++; $display("FAIL resume_instr got %b/%h/%h want 1/03/33", instr_valid, instr_pc, instr); end
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin tick(); seen = halted; end
        n_checks++; if ({halted, rom_addr} !== {1'b1, 8'h05}) begin n_fail++; $display("FAIL halt2 got %b/%h want 1/05", halted, rom_addr); end
        resume = 1'b1; jump_en = 1'b1; jump_addr = 8'h10;
        tick();
        resume = 1'b0; jump_en = 1'b0;
        n_checks++; if ({halted, rom_addr} !== {1'b0, 8'h10}) begin n_fail++; $display("FAIL jump_priority got %b/%h want 0/10", halted, rom_addr); end
        tick();
        n_checks++; if ({instr_valid, instr_pc, instr} !== {1'b1, 8'h10, 8'h77}) begin n_fail++; $display("FAIL jump_from_halt got %b/%h/%h want 1/10/77", instr_valid, instr_pc, instr); end
    endtask

    task automatic test_rst_mid();
        fill_rom_counting();
        rom[0] = 8'h42; rom[1] = 8'h43;
        instr_ready = 1'b0;
        do_reset();
        tick();
        n_checks++; if ({instr_valid, instr} !== {1'b1, 8'h42}) begin n_fail++; $display("FAIL rstmid_pre got %b/%h want 1/42", instr_valid, instr); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if ({instr_valid, halted, instr, instr_pc, rom_addr} !== 26'h0) begin n_fail++; $display("FAIL rstmid_async got %b/%b/%h/%h/%h want 0/0/00/00/00", instr_valid, halted, instr, instr_pc, rom_addr); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_checks++; if ({instr_valid, instr_pc, instr} !== {1'b1, 8'h00, 8'h42}) begin n_fail++; $display("FAIL rstmid_restart got %b/%h/%h want 1/00/42", instr_valid, instr_pc, instr); end
    endtask

    // Model: the address of the next instruction the decoder should see, advanced per handshake/halt exit.
    task automatic test_random();
        logic [7:0] exp_pc = 8'h00;
        logic [7:0] exp_next;
        bit prev_fetch = 1'b0;
        bit is_halt;
        for (int i = 0; i < 256; i++) rom[i] = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
        step_mode = 1'b0;
        instr_ready = 1'b0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            exp_next = exp_pc + 8'd1;
            is_halt = (rom[exp_pc] == 8'hFF);
            if (prev_fetch) begin
                n_checks++; if ({halted, instr_valid} !== {is_halt, !is_halt}) begin n_fail++; $display("FAIL rand_after_fetch[%0d] got %b%b want %b%b", c, halted, instr_valid, is_halt, !is_halt); end
            end
            if (instr_valid === 1'b1) begin
                n_checks++; if ({instr_pc, instr, rom_addr, halted} !== {exp_pc, rom[exp_pc], exp_next, 1'b0}) begin n_fail++; $display("FAIL rand_valid[%0d] got %h/%h/%h/%b want %h/%h/%h/0", c, instr_pc, instr, rom_addr, halted, exp_pc, rom[exp_pc], exp_next); end
            end else if (halted === 1'b1) begin
                n_checks++; if ({is_halt, rom_addr} !== {1'b1, exp_pc}) begin n_fail++; $display("FAIL rand_halted[%0d] got rom %h addr %h want ff/%h", c, rom[exp_pc], rom_addr, exp_pc); end
            end else begin
                n_checks++; if ({prev_fetch, rom_addr} !== {1'b0, exp_pc}) begin n_fail++; $display("FAIL rand_fetch[%0d] got %b/%h want 0/%h", c, prev_fetch, rom_addr, exp_pc); end
            end
            instr_ready = ($urandom_range(0, 3) != 0);
            jump_en     = ($urandom_range(0, 3) == 0);
            jump_addr   = 8'($urandom);
            resume      = ($urandom_range(0, 2) == 0);
            if (instr_valid === 1'b1 && instr_ready) exp_pc = jump_en ? jump_addr : exp_next;
            else if (halted === 1'b1) exp_pc = jump_en ? jump_addr : (resume ? exp_next : exp_pc);
            prev_fetch = (instr_valid !== 1'b1) && (halted !== 1'b1);
            tick();
        end
        jump_en = 1'b0;
        resume = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fill_rom(8'hFF);
        test_reset();
        test_basic();
        test_stall_jump();
        test_wrap();
        test_step();
        test_halt_resume();
        test_rst_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
